mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access stage sitting directly upstream of the byte-addressed, big-endian 32-bit data memory.
- Accepts load/store requests from the pipeline and validates alignment and range.
- Performs byte, halfword and word accesses; sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data through a valid/ready response handshake.

Parameters:
MEM_DEPTH, 250000, highest valid byte index of the attached memory (memory spans 0..MEM_DEPTH).

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
req_signed  input  1  sign-extend sub-word loads; ignored for stores and words.
req_addr  input  32  byte address.
req_wdata  input  32  store data; byte in [7:0], half in [15:0].
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts the response.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  misaligned, reserved size, or out-of-range request.
mem_addr  output  32  memory byte address.
mem_wdata  output  32  memory write word, big-endian.
mem_rw  output  1  1 = read, 0 = write.
mem_en  output  1  memory enable.
mem_rdata  input  32  combinational read of bytes addr..addr+3, with addr in [31:24].

Behaviour:
- Reset is asynchronous and active-low.
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0.
  - Internal registers are cleared.
- Error check at acceptance; any one condition sets error:
  - size 11;
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - addr+3 > MEM_DEPTH, computed at 33 bits so it cannot wrap.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready=1; memory outputs hold their idle values.
  - A request is accepted on the edge where req_valid is high. At that edge the unit latches addr, size, signed, we and wdata.
  - Next state:
    - error → RESP;
    - load → RD;
    - word store → WR;
    - byte/half store → RMW_RD.
- RD:
  - Drives mem_en=1, mem_rw=1, mem_addr=latched addr.
  - At the edge it captures the result and goes to RESP:
    - byte result = mem_rdata[31:24];
    - half result = mem_rdata[31:16];
    - word result = mem_rdata;
    - sub-word results are extended per req_signed.
- RMW_RD:
  - Same memory drive as RD.
  - At the edge it latches the merge word and goes to WR:
    - byte store: merge = {wdata[7:0], mem_rdata[23:0]};
    - half store: merge = {wdata[15:0], mem_rdata[15:0]}.
- WR:
  - Drives mem_en=1, mem_rw=0, mem_addr=addr.
  - mem_wdata = merge word, or latched wdata for word stores.
  - The memory write commits at the end of this cycle; next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - Leaves to IDLE on the edge where resp_ready is high.
  - Outputs stay registered until the handshake.
  - req_ready=0, so a new req_valid is ignored and not latched.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: one request in flight; at most one new accept per IDLE cycle.
- Outside RD, RMW_RD and WR, mem_en=0. An error request never asserts mem_en.
- An RMW byte store at addr rewrites addr+1..addr+3 with their just-read values, leaving them unchanged.
- Reset mid-operation:
  - mem_en drops immediately and asynchronously, so no write occurs at the next edge.
  - Any in-flight request is discarded with no response.
- Response fields on a store: resp_rdata=0. On an error: resp_err=1 and resp_rdata=0.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 → memory bytes 0x100..0x103 = DE,AD,BE,EF; load returns 0xDEADBEEF, err=0; each has resp_valid 2 cycles after accept.
- Byte store 0x000000A5 @0x101 → mem_en high for 2 cycles (rw 1 then 0); subsequent word load @0x100 returns 0xDEA5BEEF; resp 3 cycles after accept.
- Signed byte load @0x101 → 0xFFFFFFA5; unsigned byte load @0x101 → 0x000000A5; signed half load @0x102 → 0xFFFFBEEF; unsigned half load @0x102 → 0x0000BEEF.
- Error cases, all giving resp_err=1, rdata=0, resp 1 cycle after accept, mem_en never high:
  - half load @0x103;
  - word store @0x102;
  - size 11;
  - word load @250000.
- Word load @249996 → err=0.
- Backpressure: hold resp_ready=0 for 3 cycles while req_valid=1 → resp_valid/resp_rdata stable, req_ready=0, second request not accepted until one cycle after the handshake.
- Assert reset_n=0 during RMW_RD of a byte store @0x100 → all outputs take their reset values immediately, memory content unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------------------------------------------------------------------
// Memory-access stage in front of a byte-addressed, big-endian 32-bit data
// memory. It accepts one load/store request at a time, checks alignment and
// range, runs the memory transaction (read-modify-write for sub-word stores)
// and returns extended load data through a valid/ready response handshake.
//
// Ports:
//   clock       rising-edge system clock
//   reset_n     asynchronous, active-low reset
//   req_valid   request present; accepted on any edge where the unit is IDLE
//   req_ready   unit can accept a request (high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 reserved
//   req_signed  sign-extend sub-word loads
//   req_addr    byte address
//   req_wdata   store data, right-justified (byte in [7:0], half in [15:0])
//   resp_valid  response available
//   resp_ready  consumer accepts the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    misaligned, reserved size or out-of-range request
//   mem_addr    memory byte address
//   mem_wdata   memory write word, big-endian (addr byte in [31:24])
//   mem_rw      1 = read, 0 = write
//   mem_en      memory enable
//   mem_rdata   combinational read of bytes addr..addr+3, addr byte in [31:24]
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 250000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  state_t      state;
  state_t      next_state;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic [32:0] last_byte;
  logic        req_err;
  logic        accept;
  logic [31:0] load_result;
  logic [31:0] merge_word;

  // The last byte touched is computed one bit wider so that addresses near
  // 2^32 cannot wrap around and slip past the range check.
  assign last_byte = {1'b0, req_addr} + 33'd3;

  // Any single condition flags the request; an errored request goes straight
  // to RESP and never touches the memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SIZE_RSVD) begin
      req_err = 1'b1;
    end
    if ((req_size == SIZE_HALF) && req_addr[0]) begin
      req_err = 1'b1;
    end
    if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
    if (last_byte > 33'(MEM_DEPTH)) begin
      req_err = 1'b1;
    end
  end

  assign accept = (state == IDLE) && req_valid;

  // Big-endian memory: the addressed byte is always in [31:24], so sub-word
  // results come from the top of the read word.
  always_comb begin
    load_result = mem_rdata;
    case (size_q)
      SIZE_BYTE: begin
        load_result = {{24{signed_q & mem_rdata[31]}}, mem_rdata[31:24]};
      end
      SIZE_HALF: begin
        load_result = {{16{signed_q & mem_rdata[31]}}, mem_rdata[31:16]};
      end
      default: begin
        load_result = mem_rdata;
      end
    endcase
  end

  // Sub-word stores replace only the leading byte(s); the remaining bytes are
  // written back with the values just read so they stay unchanged.
  always_comb begin
    if (size_q == SIZE_BYTE) begin
      merge_word = {wdata_q[7:0], mem_rdata[23:0]};
    end else begin
      merge_word = {wdata_q[15:0], mem_rdata[15:0]};
    end
  end

  // State register. Reset returns to IDLE, which also drops mem_en at once
  // because the memory controls are decoded from the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory/handshake decode. Everything defaults to the idle
  // values so any state not driving the memory leaves it disabled.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_rw     = 1'b1;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            next_state = RESP;
          end else if (!req_we) begin
            next_state = RD;
          end else if (req_size == SIZE_WORD) begin
            next_state = WR;
          end else begin
            next_state = RMW_RD;
          end
        end
      end
      RD: begin
        mem_en     = 1'b1;
        mem_rw     = 1'b1;
        mem_addr   = addr_q;
        next_state = RESP;
      end
      RMW_RD: begin
        mem_en     = 1'b1;
        mem_rw     = 1'b1;
        mem_addr   = addr_q;
        next_state = WR;
      end
      WR: begin
        mem_en     = 1'b1;
        mem_rw     = ~we_q;
        mem_addr   = addr_q;
        mem_wdata  = (size_q == SIZE_WORD) ? wdata_q : merge_q;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch and response registers. The response is cleared at accept
  // time so stores and errors report zero data; loads overwrite it from RD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        signed_q   <= req_signed;
        we_q       <= req_we;
        wdata_q    <= req_wdata;
        resp_rdata <= 32'h0;
        resp_err   <= req_err;
      end
      if (state == RD) begin
        resp_rdata <= load_result;
      end
      if (state == RMW_RD) begin
        merge_q <= merge_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// ---------------------------------------------------------------------------
// Self-checking bench for mem_access_unit. A big-endian byte memory model is
// attached to the memory port; expected responses are queued when a request
// is issued and compared when the unit produces its response.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int DEPTH = 250000;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic        mem_en;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:DEPTH];
  logic [17:0] ra;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en_cnt;
    logic [3:0]  rw_hist;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_en     (mem_en),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational big-endian read of addr..addr+3; out-of-range reads give 0.
  always_comb begin
    ra = mem_addr[17:0];
    mem_rdata = 32'h0;
    if (({1'b0, mem_addr} + 33'd3) <= 33'(DEPTH)) begin
      mem_rdata = {mem[ra], mem[ra + 18'd1], mem[ra + 18'd2], mem[ra + 18'd3]};
    end
  end

  // Writes commit at the end of a cycle with mem_en high and mem_rw low.
  always @(posedge clock) begin
    if (mem_en && !mem_rw && (({1'b0, mem_addr} + 33'd3) <= 33'(DEPTH))) begin
      mem[mem_addr[17:0]]          <= mem_wdata[31:24];
      mem[mem_addr[17:0] + 18'd1]  <= mem_wdata[23:16];
      mem[mem_addr[17:0] + 18'd2]  <= mem_wdata[15:8];
      mem[mem_addr[17:0] + 18'd3]  <= mem_wdata[7:0];
    end
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  function automatic exp_t mk(input logic [31:0] rd, input logic err, input int lat,
                              input int en, input logic [3:0] rw);
    exp_t e;
    e.rdata   = rd;
    e.err     = err;
    e.lat     = lat;
    e.en_cnt  = en;
    e.rw_hist = rw;
    return e;
  endfunction

  function automatic logic [31:0] memWord(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkValue({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkValue({pfx, "_resp_rdata"}, resp_rdata, 32'd0);
    checkValue({pfx, "_resp_err"}, 32'(resp_err), 32'd0);
    checkValue({pfx, "_mem_en"}, 32'(mem_en), 32'd0);
    checkValue({pfx, "_mem_rw"}, 32'(mem_rw), 32'd1);
    checkValue({pfx, "_mem_addr"}, mem_addr, 32'd0);
    checkValue({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
    checkValue({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Present one request at the falling edge, let it be accepted on the next
  // rising edge and queue what the response must look like.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input exp_t e);
    @(negedge clock);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    checkValue("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the response counting edges from the accept edge,
  // record memory activity, compare against the queued expectation, optionally
  // stall for 'hold' cycles, then complete the handshake.
  task automatic checkOutput(input int hold);
    int         lat;
    int         en_cnt;
    logic [3:0] rw_hist;
    exp_t       e;
    lat     = 1;
    en_cnt  = 0;
    rw_hist = 4'b0000;
    while ((resp_valid !== 1'b1) && (lat < 10)) begin
      if (mem_en) begin
        en_cnt++;
        rw_hist = {rw_hist[2:0], mem_rw};
      end
      @(posedge clock);
      #1;
      lat++;
    end
    if (mem_en) begin
      en_cnt++;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
      return;
    end
    e = sb.pop_front();
    checkValue("resp_valid", 32'(resp_valid), 32'd1);
    checkValue("latency", 32'(lat), 32'(e.lat));
    checkValue("resp_rdata", resp_rdata, e.rdata);
    checkValue("resp_err", 32'(resp_err), 32'(e.err));
    checkValue("mem_en_cycles", 32'(en_cnt), 32'(e.en_cnt));
    checkValue("mem_rw_seq", 32'(rw_hist), 32'(e.rw_hist));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      checkValue("hold_resp_valid", 32'(resp_valid), 32'd1);
      checkValue("hold_resp_rdata", resp_rdata, e.rdata);
      checkValue("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    checkValue("resp_valid_after_hs", 32'(resp_valid), 32'd0);
    checkValue("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    #2;
    checkResetValues("por");
    @(negedge clock);
    reset_n = 1'b1;

    // Word store then word load at 0x100.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, mk(32'h0, 1'b0, 2, 1, 4'b0000));
    checkOutput(0);
    checkValue("mem_after_word_store", memWord(32'h100), 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, mk(32'hDEADBEEF, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);

    // Byte store through read-modify-write, neighbours must survive.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, mk(32'h0, 1'b0, 3, 2, 4'b0010));
    checkOutput(0);
    checkValue("mem_after_byte_store", memWord(32'h100), 32'hDEA5BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, mk(32'hDEA5BEEF, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);

    // Sub-word loads with and without sign extension.
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, mk(32'hFFFFFFA5, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, mk(32'h000000A5, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, mk(32'hFFFFBEEF, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, mk(32'h0000BEEF, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);

    // Error requests: one-cycle response, no memory activity.
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, mk(32'h0, 1'b1, 1, 0, 4'b0000));
    checkOutput(0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D, mk(32'h0, 1'b1, 1, 0, 4'b0000));
    checkOutput(0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, mk(32'h0, 1'b1, 1, 0, 4'b0000));
    checkOutput(0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd250000, 32'h0, mk(32'h0, 1'b1, 1, 0, 4'b0000));
    checkOutput(0);
    checkValue("mem_after_errors", memWord(32'h100), 32'hDEA5BEEF);

    // Highest legal word.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'd249996, 32'h12345678, mk(32'h0, 1'b0, 2, 1, 4'b0000));
    checkOutput(0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd249996, 32'h0, mk(32'h12345678, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);

    // Backpressure: a second request waits on req_valid during the stall and
    // must only be taken on the edge after the handshake.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, mk(32'hDEA5BEEF, 1'b0, 2, 1, 4'b0001));
    @(negedge clock);
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'd249996;
    req_valid  = 1'b1;
    checkOutput(3);
    sb.push_back(mk(32'h12345678, 1'b0, 2, 1, 4'b0001));
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    checkOutput(0);

    // Reset in the read half of a byte store: nothing may be written.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000011, mk(32'h0, 1'b0, 3, 2, 4'b0010));
    checkValue("rmw_rd_mem_en", 32'(mem_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("midop");
    @(posedge clock);
    #1;
    checkValue("reset_held_mem_en", 32'(mem_en), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    checkValue("mem_after_reset", memWord(32'h100), 32'hDEA5BEEF);
    checkValue("idle_after_reset", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, mk(32'hDEA5BEEF, 1'b0, 2, 1, 4'b0001));
    checkOutput(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
